// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// MDU wait timeout and statistics counter width.
package hazard_pkg;

  typedef logic [0:0] state_t;

  localparam state_t RUN      = 1'b0;
  localparam state_t MDU_WAIT = 1'b1;

  localparam int MDU_TIMEOUT = 64;
  localparam int STAT_W      = 16;
  localparam int WAIT_W      = $clog2(MDU_TIMEOUT + 1);

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: branch flush, load-use stall and multi-cycle
// MDU hold with timeout, plus saturating stall/flush statistics.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RUN      | normal flow; branch, MDU start and load-use hazards resolved
//   MDU_WAIT | pipeline held with EX/MEM bubbles until mdu_done or timeout
module hazard_controller
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic [4:0]        rs1_ID,
  input  logic [4:0]        rs2_ID,
  input  logic              uses_rs1_ID,
  input  logic              uses_rs2_ID,
  input  logic [4:0]        rd_EX,
  input  logic              mem_read_EX,
  input  logic              branch_taken_EX,
  input  logic              mdu_start_EX,
  input  logic              mdu_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mdu_abort,
  output logic              busy,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_count
);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use;
  logic              flush_inc;
  logic              stall_inc;

  assign load_use = mem_read_EX && (rd_EX != 5'd0) &&
                    ((uses_rs1_ID && (rd_EX == rs1_ID)) ||
                     (uses_rs2_ID && (rd_EX == rs2_ID)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mdu_abort    = 1'b0;
    flush_inc    = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;

    if (!arst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken_EX) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (mdu_start_EX) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            state_nxt    = MDU_WAIT;
            wait_cnt_nxt = '0;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_nxt = RUN;
          end else if (wait_cnt == WAIT_W'(MDU_TIMEOUT)) begin
            // give up on the MDU; the pipeline advances as if it had finished
            mdu_abort = 1'b1;
            state_nxt = RUN;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign busy      = arst_n && (state == MDU_WAIT);
  assign stall_inc = arst_n && !pc_write;

  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (!arst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (!arst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed vector table, multi-cycle
// MDU/timeout/saturation sequences and randomized traffic against a reference model.
module tb_hazard_controller;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       mr;
    logic       br;
    logic       ms;
    logic       md;
    logic [7:0] exp;  // pc,ifw,idw,iff,idf,emf,abort,busy
  } vec_t;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        uses_rs1_ID, uses_rs2_ID, mem_read_EX, branch_taken_EX;
  logic        mdu_start_EX, mdu_done;
  logic        pc_write, if_id_write, id_ex_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mdu_abort, busy;
  logic [15:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_busy;
  int m_waited;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .uses_rs1_ID     (uses_rs1_ID),
    .uses_rs2_ID     (uses_rs2_ID),
    .rd_EX           (rd_EX),
    .mem_read_EX     (mem_read_EX),
    .branch_taken_EX (branch_taken_EX),
    .mdu_start_EX    (mdu_start_EX),
    .mdu_done        (mdu_done),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mdu_abort       (mdu_abort),
    .busy            (busy),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  function automatic logic [7:0] obs();
    return {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
            ex_mem_flush, mdu_abort, busy};
  endfunction

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic u1, logic u2, logic mr, logic br, logic ms,
                              logic md, logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.br = br; v.ms = ms; v.md = md; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] model_out(vec_t v, bit rst_n);
    bit lu;
    lu = v.mr && (v.rd != 0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    if (!rst_n)  return 8'b000_111_0_0;
    if (m_busy) begin
      if (v.md || m_waited >= 64) return {6'b111_000, !v.md, 1'b1};
      return 8'b000_001_0_1;
    end
    if (v.br)    return 8'b111_110_0_0;
    if (v.ms)    return 8'b000_001_0_0;
    if (lu)      return 8'b001_010_0_0;
    return 8'b111_000_0_0;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle (entered just after a falling edge), compare, advance model.
  task automatic step(vec_t v, bit rst_n, bit chk, string name);
    logic [7:0] e;
    arst_n = rst_n;
    rs1_ID = v.rs1; rs2_ID = v.rs2; rd_EX = v.rd;
    uses_rs1_ID = v.u1; uses_rs2_ID = v.u2; mem_read_EX = v.mr;
    branch_taken_EX = v.br; mdu_start_EX = v.ms; mdu_done = v.md;
    #1;
    e = model_out(v, rst_n);
    if (chk) check(name, {24'd0, obs(), stall_cycles, flush_count},
                   {24'd0, e, m_stall[15:0], m_flush[15:0]});
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[7] && m_stall < 65535) m_stall++;
      if (!m_busy && v.br && m_flush < 65535) m_flush++;
      if (m_busy) begin
        if (e[7]) m_busy = 0;
        else m_waited++;
      end else if (!v.br && v.ms) begin
        m_busy = 1;
        m_waited = 0;
      end
    end
    @(negedge clk);
  endtask

  vec_t idle;
  vec_t lu27;
  vec_t tbl[$];

  initial begin
    int k;
    int busy_n;
    bit adv_seen;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    lu27 = mk(0, 5, 5, 0, 1, 1, 0, 0, 0, 8'h00);

    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b111_000_00));   // idle
    tbl.push_back(mk(0, 5, 5, 0, 1, 1, 0, 0, 0, 8'b001_010_00));   // load-use rs2
    tbl.push_back(mk(0, 5, 5, 0, 1, 1, 1, 0, 0, 8'b111_110_00));   // branch beats load-use
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 8'b111_000_00));   // x0 load
    tbl.push_back(mk(31, 0, 31, 1, 0, 1, 0, 0, 0, 8'b001_010_00)); // load-use rs1
    tbl.push_back(mk(7, 0, 7, 0, 0, 1, 0, 0, 0, 8'b111_000_00));   // rs1 match unused
    tbl.push_back(mk(7, 7, 7, 1, 1, 0, 0, 0, 0, 8'b111_000_00));   // not a load
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b111_000_00));   // done ignored in RUN
    tbl.push_back(mk(3, 4, 9, 1, 1, 1, 1, 0, 0, 8'b111_110_00));   // branch only

    m_busy = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    step(idle, 0, 0, "rst");
    arst_n = 0; #1;
    check("reset_outputs", {56'd0, obs()}, {56'd0, 8'b000_111_00});
    @(negedge clk);
    step(idle, 0, 1, "reset_model");

    // vector table
    foreach (tbl[i]) begin
      arst_n = 1;
      rs1_ID = tbl[i].rs1; rs2_ID = tbl[i].rs2; rd_EX = tbl[i].rd;
      uses_rs1_ID = tbl[i].u1; uses_rs2_ID = tbl[i].u2; mem_read_EX = tbl[i].mr;
      branch_taken_EX = tbl[i].br; mdu_start_EX = tbl[i].ms; mdu_done = tbl[i].md;
      #1;
      check($sformatf("table_%0d", i), {56'd0, obs()}, {56'd0, tbl[i].exp});
      step(tbl[i], 1, 1, $sformatf("table_model_%0d", i));
    end

    // single load-use stall
    step(idle, 0, 0, "rst");
    step(lu27, 1, 1, "lu_cycle");
    step(idle, 1, 1, "lu_after");
    check("lu_stall_count", {48'd0, stall_cycles}, 64'd1);

    // branch + load-use together
    step(idle, 0, 0, "rst");
    lu27.br = 1;
    step(lu27, 1, 1, "br_lu_cycle");
    lu27.br = 0;
    step(idle, 1, 1, "br_lu_after");
    check("br_lu_counts", {32'd0, stall_cycles, flush_count}, {32'd0, 16'd0, 16'd1});

    // MDU with done five cycles after start
    step(idle, 0, 0, "rst");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 1, "mdu_start");
    busy_n = 0; adv_seen = 0;
    for (int c = 1; c <= 5; c++) begin
      vec_t v;
      v = idle;
      v.md = (c == 5);
      arst_n = 1; mdu_done = v.md; #1;
      if (busy) busy_n++;
      if (c == 5 && busy && pc_write && !ex_mem_flush) adv_seen = 1;
      step(v, 1, 1, $sformatf("mdu_wait_%0d", c));
    end
    check("mdu_busy_cycles", 64'(busy_n), 64'd5);
    check("mdu_advance_on_done", 64'(adv_seen), 64'd1);
    check("mdu_stall_count", {48'd0, stall_cycles}, 64'd5);
    step(idle, 1, 1, "mdu_back_run");

    // timeout
    step(idle, 0, 0, "rst");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 1, "to_start");
    k = 0;
    while (k < 200) begin
      arst_n = 1; mdu_done = 0; mdu_start_EX = 0; #1;
      if (mdu_abort) break;
      step(idle, 1, 1, "to_wait");
      k++;
    end
    check("timeout_wait_index", 64'(k), 64'd64);
    step(idle, 1, 1, "to_abort_cycle");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 1, "to_late_done");
    check("timeout_back_run", {63'd0, busy}, 64'd0);

    // randomized traffic
    step(idle, 0, 0, "rst");
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.rd  = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom); v.mr = 1'($urandom);
      v.br = ($urandom_range(0, 5) == 0);
      v.ms = ($urandom_range(0, 15) == 0);
      v.md = ($urandom_range(0, 7) == 0);
      v.exp = 0;
      step(v, ($urandom_range(0, 99) != 0), 1, "random");
    end

    // saturation, then reset while waiting on the MDU
    step(idle, 0, 0, "rst");
    for (int n = 0; n < 70000; n++) step(lu27, 1, 0, "sat");
    step(lu27, 1, 1, "sat_model");
    check("stall_saturated", {48'd0, stall_cycles}, 64'h0000_0000_0000_FFFF);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1, 1, "sat_mdu_start");
    step(idle, 1, 1, "sat_mdu_wait1");
    step(idle, 1, 1, "sat_mdu_wait2");
    arst_n = 0; #1;
    check("rst_in_wait_outputs", {56'd0, obs()}, {56'd0, 8'b000_111_00});
    step(idle, 0, 1, "rst_in_wait");
    arst_n = 1; #1;
    check("post_rst_state", {31'd0, busy, mdu_abort, stall_cycles, flush_count}, 64'd0);
    step(idle, 1, 1, "post_rst_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
